mux: RTL and testbench
======================

# mux

Parameterized WORDS-to-1 word selector used throughout the pipeline for data, address and enable steering: register-write data, register-write address and write-enable selection in the memory stage. The primary output is purely combinational, so it can sit between pipeline registers and the register file without adding a cycle. A registered copy of the selection and an out-of-range flag are provided for timing-critical consumers and debug.

## Interface
Parameters:
- BITS, default 64: width of each input word and of the outputs.
- WORDS, default 2: number of input words; legal range 1..256.
- SEL_W, derived: max(1, ceil(log2(WORDS))); not overridable. WORDS=2 gives 1, WORDS=4 gives 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sel  input  SEL_W  index of the word to forward.
- in  input  WORDS x BITS  unpacked word array, indices 0..WORDS-1.
- out  output  BITS  combinational selected word.
- out_q  output  BITS  registered copy of out.
- sel_q  output  SEL_W  registered copy of sel.
- sel_err  output  1  combinational; 1 when sel >= WORDS.
- sel_err_q  output  1  registered copy of sel_err.

## Operation
- out = in[sel] when sel < WORDS; out = all zeros when sel >= WORDS. This case is reachable only when WORDS is not a power of two.
- sel_err = (sel >= WORDS). It is constant 0 when WORDS is a power of two.
- WORDS=1: the sel bit is ignored, out = in[0] and sel_err = 0.
- out has no dependence on clk or rst_n: no latch, no enable, no X-propagation beyond the selected word. Any change on sel or on the selected word appears on out in the same cycle.
- Registered path, on each rising clk: out_q <= out, sel_q <= sel, sel_err_q <= sel_err.
- Reset: while rst_n = 0, out_q = 0, sel_q = 0 and sel_err_q = 0, immediately and without waiting for clk. The combinational outputs are unaffected by reset.
- The first rising edge after rst_n deasserts captures normally.
- Unselected words have no effect on any output.

## Timing
- out and sel_err: zero-cycle latency; they follow their inputs within the same cycle.
- out_q, sel_q and sel_err_q: one-cycle latency. The value present before edge N appears after edge N and holds until edge N+1.
- No handshake and no back-pressure; a new selection is accepted every cycle.
- Reset asserted mid-operation clears the registered outputs asynchronously; out keeps tracking in[sel].
- Simultaneous change of sel and of the in words before an edge: the registers capture the settled pre-edge combinational result.

## Test plan
- BITS=64, WORDS=4; in = {0x1111, 0x2222, 0x3333, 0x4444}; sweep sel 0..3 -> out = 0x1111, 0x2222, 0x3333, 0x4444 in the same cycle; sel_err = 0 throughout.
- BITS=5, WORDS=2; in[0]=5'd7, in[1]=5'd19; sel=0 then sel=1 -> out = 7 then 19. Change in[0] to 3 while sel=1 -> out stays 19.
- BITS=8, WORDS=3; sel=3 -> out = 0x00, sel_err = 1. After one edge, sel_err_q = 1 and sel_q = 3.
- Registered path with WORDS=4: sel = 2 before edge N -> out_q = in[2] and sel_q = 2 after edge N. Then sel = 0 -> out_q still equals in[2] until edge N+1.
- Drive rst_n low between edges while out_q = 0x3333 -> out_q, sel_q and sel_err_q go to 0 immediately, while out still equals in[sel]. Release rst_n -> the next edge captures normally.
- BITS=1, WORDS=1; toggle sel -> out always equals in[0] and sel_err stays 0.

Source files
------------

// File: rtl/mux.sv
// WORDS-to-1 word selector with a combinational output, an out-of-range flag,
// and registered copies of the selection for timing-critical consumers.
module mux #(
  parameter  int BITS  = 64,
  parameter  int WORDS = 2,
  localparam int SEL_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic [BITS-1:0]  in [WORDS],
  output logic [BITS-1:0]  out,
  output logic [BITS-1:0]  out_q,
  output logic [SEL_W-1:0] sel_q,
  output logic             sel_err,
  output logic             sel_err_q
);

  if (WORDS < 1 || WORDS > 256) begin : g_bad_words
    $error("mux: WORDS must be in 1..256");
  end

  if (WORDS == 1) begin : g_single
    // A single word is always forwarded; sel only feeds the debug register.
    always_comb begin
      out     = in[0];
      sel_err = 1'b0;
    end
  end else if ((2 ** SEL_W) == WORDS) begin : g_pow2
    // Every sel encoding names a real word, so no range check is needed.
    always_comb begin
      out     = in[sel];
      sel_err = 1'b0;
    end
  end else begin : g_range
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(WORDS - 1);

    // NOTE: assigning every output first keeps this block free of latches.
    always_comb begin
      out     = '0;
      sel_err = 1'b0;
      if (sel > LastIdx) begin
        sel_err = 1'b1;
      end else begin
        out = in[sel];
      end
    end
  end

  // NOTE: non-blocking assignments so all three copies sample the same pre-edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= out;
      sel_q     <= sel;
      sel_err_q <= sel_err;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux: four parameterisations driven with directed
// and random stimulus, compared against a behavioural selection model.
module tb_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // BITS=64, WORDS=4
  logic [1:0]  sel4;
  logic [63:0] in4 [4];
  logic [63:0] out4, out4_q;
  logic [1:0]  sel4_q;
  logic        err4, err4_q;

  // BITS=5, WORDS=2
  logic [0:0]  sel2;
  logic [4:0]  in2 [2];
  logic [4:0]  out2, out2_q;
  logic [0:0]  sel2_q;
  logic        err2, err2_q;

  // BITS=8, WORDS=3
  logic [1:0]  sel3;
  logic [7:0]  in3 [3];
  logic [7:0]  out3, out3_q;
  logic [1:0]  sel3_q;
  logic        err3, err3_q;

  // BITS=1, WORDS=1
  logic [0:0]  sel1;
  logic [0:0]  in1 [1];
  logic [0:0]  out1, out1_q;
  logic [0:0]  sel1_q;
  logic        err1, err1_q;

  mux #(.BITS(64), .WORDS(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .sel(sel4), .in(in4), .out(out4), .out_q(out4_q),
    .sel_q(sel4_q), .sel_err(err4), .sel_err_q(err4_q));
  mux #(.BITS(5), .WORDS(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .sel(sel2), .in(in2), .out(out2), .out_q(out2_q),
    .sel_q(sel2_q), .sel_err(err2), .sel_err_q(err2_q));
  mux #(.BITS(8), .WORDS(3)) u_m3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .in(in3), .out(out3), .out_q(out3_q),
    .sel_q(sel3_q), .sel_err(err3), .sel_err_q(err3_q));
  mux #(.BITS(1), .WORDS(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .sel(sel1), .in(in1), .out(out1), .out_q(out1_q),
    .sel_q(sel1_q), .sel_err(err1), .sel_err_q(err1_q));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference selection rule: word at index s if it exists, else zero.
  function automatic logic [63:0] model4(input int s);
    return (s < 4) ? in4[s] : 64'd0;
  endfunction

  function automatic logic [63:0] model3(input int s);
    return (s < 3) ? 64'(in3[s]) : 64'd0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_out4, exp_out3;
    int          exp_sel4, exp_sel3;
    logic        exp_err3;

    rst_n = 1'b0;
    sel4 = 2'd0; sel2 = 1'b0; sel3 = 2'd0; sel1 = 1'b0;
    in4[0] = 64'h1111; in4[1] = 64'h2222; in4[2] = 64'h3333; in4[3] = 64'h4444;
    in2[0] = 5'd7; in2[1] = 5'd19;
    in3[0] = 8'h10; in3[1] = 8'h20; in3[2] = 8'h30;
    in1[0] = 1'b1;

    // Reset state, including across a clock edge while held.
    #2;
    check("rst_out4_q", out4_q, 64'd0);
    check("rst_sel4_q", 64'(sel4_q), 64'd0);
    check("rst_err3_q", 64'(err3_q), 64'd0);
    check("rst_out4_comb", out4, 64'h1111);
    @(posedge clk); #1;
    check("rst_hold_out4_q", out4_q, 64'd0);
    check("rst_hold_out1_q", 64'(out1_q), 64'd0);
    rst_n = 1'b1;

    // WORDS=4 sweep: same-cycle selection, never out of range.
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      #1;
      check("sweep_out4", out4, 64'h1111 * 64'(s + 1));
      check("sweep_err4", 64'(err4), 64'd0);
    end

    // Registered path latency.
    sel4 = 2'd2;
    @(posedge clk); #1;
    check("reg_out4_q", out4_q, 64'h3333);
    check("reg_sel4_q", 64'(sel4_q), 64'd2);
    sel4 = 2'd0;
    #1;
    check("reg_hold_out4_q", out4_q, 64'h3333);
    check("reg_new_out4", out4, 64'h1111);
    @(posedge clk); #1;
    check("reg_next_out4_q", out4_q, 64'h1111);

    // Mid-cycle asynchronous reset.
    sel4 = 2'd2;
    @(posedge clk); #1;
    check("pre_rst_out4_q", out4_q, 64'h3333);
    rst_n = 1'b0;
    #1;
    check("async_rst_out4_q", out4_q, 64'd0);
    check("async_rst_sel4_q", 64'(sel4_q), 64'd0);
    check("async_rst_err4_q", 64'(err4_q), 64'd0);
    check("async_rst_out4", out4, 64'h3333);
    #2;
    rst_n = 1'b1;
    sel4 = 2'd1;
    @(posedge clk); #1;
    check("post_rst_out4_q", out4_q, 64'h2222);
    check("post_rst_sel4_q", 64'(sel4_q), 64'd1);

    // WORDS=2, 5-bit words; unselected word must not leak.
    sel2 = 1'b0; #1;
    check("w2_sel0", 64'(out2), 64'd7);
    sel2 = 1'b1; #1;
    check("w2_sel1", 64'(out2), 64'd19);
    in2[0] = 5'd3; #1;
    check("w2_unsel_change", 64'(out2), 64'd19);
    check("w2_err", 64'(err2), 64'd0);

    // WORDS=3: out-of-range selection.
    sel3 = 2'd3; #1;
    check("w3_oor_out", 64'(out3), 64'd0);
    check("w3_oor_err", 64'(err3), 64'd1);
    @(posedge clk); #1;
    check("w3_oor_err_q", 64'(err3_q), 64'd1);
    check("w3_oor_sel_q", 64'(sel3_q), 64'd3);
    check("w3_oor_out_q", 64'(out3_q), 64'd0);

    // WORDS=1: sel ignored.
    for (int k = 0; k < 8; k++) begin
      sel1 = ~sel1;
      in1[0] = 1'($urandom);
      #1;
      check("w1_out", 64'(out1), 64'(in1[0]));
      check("w1_err", 64'(err1), 64'd0);
    end
    @(posedge clk); #1;
    check("w1_out_q", 64'(out1_q), 64'(in1[0]));

    // Random stimulus against the model, both combinational and registered.
    for (int i = 0; i < 300; i++) begin
      for (int w = 0; w < 4; w++) in4[w] = {$urandom, $urandom};
      for (int w = 0; w < 3; w++) in3[w] = 8'($urandom);
      sel4 = 2'($urandom_range(0, 3));
      sel3 = 2'($urandom_range(0, 3));
      #1;
      exp_sel4 = int'(sel4);
      exp_sel3 = int'(sel3);
      exp_out4 = model4(exp_sel4);
      exp_out3 = model3(exp_sel3);
      exp_err3 = (exp_sel3 >= 3);
      check("rnd_out4", out4, exp_out4);
      check("rnd_out3", 64'(out3), exp_out3);
      check("rnd_err3", 64'(err3), 64'(exp_err3));
      @(posedge clk); #1;
      check("rnd_out4_q", out4_q, exp_out4);
      check("rnd_sel4_q", 64'(sel4_q), 64'(exp_sel4));
      check("rnd_out3_q", 64'(out3_q), exp_out3);
      check("rnd_sel3_q", 64'(sel3_q), 64'(exp_sel3));
      check("rnd_err3_q", 64'(err3_q), 64'(exp_err3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
